// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program-counter generator for the single-issue RV32I core.
//
// Computes the next PC from the branch-condition selects, registers it, and
// issues instruction-fetch requests over a valid/ready handshake.
// It also counts retired instructions.
//
// Optional feature macro: PCGEN_MISALIGN_TRAP_EN
//   When defined, a resolve whose target is not word aligned parks the block
//   in a sticky TRAP state and raises `trap`. The PC and instret are left
//   untouched. When undefined, the misaligned target is simply fetched.
//
// Ports
//   clock      in   single clock, rising-edge
//   reset_n    in   asynchronous active-low reset
//   pcAsrc     in   addend select: 0 -> +4, 1 -> +imm
//   pcBsrc     in   base select:   0 -> pc, 1 -> rs1
//   imm        in   sign-extended branch/jump immediate
//   rs1        in   register operand for JALR
//   exec_done  in   execute stage has resolved the current instruction
//   stall      in   holds the PC update while high
//   if_valid   out  fetch request valid
//   if_ready   in   instruction memory accepts the request
//   if_addr    out  fetch address (always equal to pc)
//   pc         out  PC of the instruction in flight
//   pc_plus4   out  pc + 4, link value
//   instret    out  retired-instruction count
//   trap       out  misaligned-target trap (only with the macro defined)
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pcAsrc,
    input  logic        pcBsrc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        exec_done,
    input  logic        stall,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instret
`ifdef PCGEN_MISALIGN_TRAP_EN
    ,
    output logic        trap
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
`ifdef PCGEN_MISALIGN_TRAP_EN
        ,
        TRAP  = 2'd3
`endif
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic        r_ifValid;
`ifdef PCGEN_MISALIGN_TRAP_EN
    logic        r_trap;
`endif

    logic [31:0] w_base;
    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic [31:0] w_next;
    logic        w_isJalr;
    logic        w_resolve;

    // Next-PC datapath: base + addend, wrapping naturally at 32 bits.
    // JALR (both selects high) clears bit 0 of the target.
    assign w_base    = pcBsrc ? rs1 : r_pc;
    assign w_addend  = pcAsrc ? imm : 32'd4;
    assign w_sum     = w_base + w_addend;
    assign w_isJalr  = pcAsrc & pcBsrc;
    assign w_next    = {w_sum[31:1], w_sum[0] & ~w_isJalr};
    assign w_resolve = exec_done & ~stall;

    // Control FSM and architectural state. if_valid is registered so that
    // once a request is raised it cannot glitch or change until accepted;
    // if_addr is tied to pc, which only moves on a resolve in EXEC.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= BOOT;
            r_pc      <= RESET_VECTOR;
            r_instret <= 32'd0;
            r_ifValid <= 1'b0;
`ifdef PCGEN_MISALIGN_TRAP_EN
            r_trap    <= 1'b0;
`endif
        end else begin
            case (r_state)
                BOOT: begin
                    r_state   <= FETCH;
                    r_ifValid <= 1'b1;
                end
                FETCH: begin
                    if (r_ifValid && if_ready) begin
                        r_state   <= EXEC;
                        r_ifValid <= 1'b0;
                    end
                end
                EXEC: begin
                    if (w_resolve) begin
`ifdef PCGEN_MISALIGN_TRAP_EN
                        if (w_next[1:0] != 2'b00) begin
                            r_state <= TRAP;
                            r_trap  <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            r_pc      <= w_next;
                            r_instret <= r_instret + 32'd1;
                            r_state   <= FETCH;
                            r_ifValid <= 1'b1;
                        end
                    end
                end
`ifdef PCGEN_MISALIGN_TRAP_EN
                TRAP: begin
                    r_state   <= TRAP;
                    r_ifValid <= 1'b0;
                    r_trap    <= 1'b1;
                end
`endif
                default: begin
                    r_state   <= BOOT;
                    r_ifValid <= 1'b0;
                end
            endcase
        end
    end

    assign if_valid = r_ifValid;
    assign if_addr  = r_pc;
    assign pc       = r_pc;
    assign pc_plus4 = r_pc + 32'd4;
    assign instret  = r_instret;
`ifdef PCGEN_MISALIGN_TRAP_EN
    assign trap     = r_trap;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen.
//
// Directed table of resolves, hand-written stall / reset / misaligned
// sequences, then randomized cycles compared against a behavioural model.
// Honours PCGEN_MISALIGN_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_1000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pcAsrc = 1'b0;
    logic        pcBsrc = 1'b0;
    logic [31:0] imm = 32'd0;
    logic [31:0] rs1 = 32'd0;
    logic        exec_done = 1'b0;
    logic        stall = 1'b0;
    logic        if_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
`ifdef PCGEN_MISALIGN_TRAP_EN
    logic        trap;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic        a;
        logic        b;
        logic [31:0] immV;
        logic [31:0] rs1V;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[7];

    // Behavioural model state: 0 boot, 1 fetching, 2 executing, 3 trapped
    int          mMode;
    logic [31:0] mPc;
    logic [31:0] mInstret;
    logic [31:0] tgt;

    pc_gen #(.RESET_VECTOR(RV)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pcAsrc    (pcAsrc),
        .pcBsrc    (pcBsrc),
        .imm       (imm),
        .rs1       (rs1),
        .exec_done (exec_done),
        .stall     (stall),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_addr   (if_addr),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .instret   (instret)
`ifdef PCGEN_MISALIGN_TRAP_EN
        ,
        .trap      (trap)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic b,
                                 input logic [31:0] immV, input logic [31:0] rs1V,
                                 input logic done, input logic st, input logic rdy);
        pcAsrc    = a;
        pcBsrc    = b;
        imm       = immV;
        rs1       = rs1V;
        exec_done = done;
        stall     = st;
        if_ready  = rdy;
    endtask

    // Accept the pending fetch in one cycle.
    task automatic doFetch(input logic [31:0] expAddr);
        checkOutput("fetch.if_valid", 32'(if_valid), 32'd1);
        checkOutput("fetch.if_addr", if_addr, expAddr);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick();
        if_ready = 1'b0;
        checkOutput("fetch.accepted", 32'(if_valid), 32'd0);
    endtask

    // One resolve in EXEC, then check the redirected fetch.
    task automatic resolve(input logic a, input logic b, input logic [31:0] immV,
                           input logic [31:0] rs1V, input logic [31:0] expPc,
                           input logic [31:0] expInstret);
        applyStimulus(a, b, immV, rs1V, 1'b1, 1'b0, 1'b0);
        tick();
        exec_done = 1'b0;
        checkOutput("resolve.pc", pc, expPc);
        checkOutput("resolve.instret", instret, expInstret);
        checkOutput("resolve.if_valid", 32'(if_valid), 32'd1);
        checkOutput("resolve.if_addr", if_addr, expPc);
        checkOutput("resolve.pc_plus4", pc_plus4, expPc + 32'd4);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".pc"}, pc, RV);
        checkOutput({tag, ".if_addr"}, if_addr, RV);
        checkOutput({tag, ".if_valid"}, 32'(if_valid), 32'd0);
        checkOutput({tag, ".instret"}, instret, 32'd0);
`ifdef PCGEN_MISALIGN_TRAP_EN
        checkOutput({tag, ".trap"}, 32'(trap), 32'd0);
`endif
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_1004};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0FFC};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_3000, 32'h0000_3004};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_2005, 32'h0000_2004};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_2104};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};

        // Reset and boot
        tick();
        checkResetValues("reset");
        reset_n = 1'b1;
        checkOutput("boot.if_valid", 32'(if_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold.if_valid", 32'(if_valid), 32'd1);
            checkOutput("hold.if_addr", if_addr, RV);
            checkOutput("hold.instret", instret, 32'd0);
            if (i < 3) tick();
        end

        // Directed table of resolves
        for (int i = 0; i < 7; i++) begin
            doFetch(i == 0 ? RV : vecs[i-1].expPc);
            resolve(vecs[i].a, vecs[i].b, vecs[i].immV, vecs[i].rs1V,
                    vecs[i].expPc, 32'(i + 1));
        end

        // Stall holds the update, release applies it exactly once
        doFetch(32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("stall.pc", pc, 32'd0);
            checkOutput("stall.instret", instret, 32'd7);
            checkOutput("stall.if_valid", 32'(if_valid), 32'd0);
        end
        stall = 1'b0;
        tick();
        checkOutput("unstall.pc", pc, 32'd4);
        checkOutput("unstall.instret", instret, 32'd8);
        checkOutput("unstall.if_valid", 32'(if_valid), 32'd1);
        tick();
        checkOutput("fetch_ignores_done.instret", instret, 32'd8);
        checkOutput("fetch_ignores_done.pc", pc, 32'd4);
        exec_done = 1'b0;

        // Reset during a pending fetch
        reset_n = 1'b0;
        #1;
        checkResetValues("rst_fetch");
        tick();
        reset_n = 1'b1;
        tick();
        doFetch(RV);

        // Reset during EXEC, then restart from the reset vector
        reset_n = 1'b0;
        #1;
        checkResetValues("rst_exec");
        tick();
        reset_n = 1'b1;
        checkOutput("rst_exec.boot", 32'(if_valid), 32'd0);
        tick();
        doFetch(RV);

        // JALR to a misaligned target
        applyStimulus(1'b1, 1'b1, 32'd0, 32'h0000_2003, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef PCGEN_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("trap.trap", 32'(trap), 32'd1);
            checkOutput("trap.pc", pc, RV);
            checkOutput("trap.instret", instret, 32'd0);
            checkOutput("trap.if_valid", 32'(if_valid), 32'd0);
            tick();
        end
        reset_n = 1'b0;
        #1;
        checkResetValues("rst_trap");
        tick();
        reset_n = 1'b1;
        tick();
        checkOutput("rst_trap.refetch", 32'(if_valid), 32'd1);
        checkOutput("rst_trap.if_addr", if_addr, RV);
`else
        exec_done = 1'b0;
        checkOutput("jalr_mis.pc", pc, 32'h0000_2002);
        checkOutput("jalr_mis.if_addr", if_addr, 32'h0000_2002);
        checkOutput("jalr_mis.if_valid", 32'(if_valid), 32'd1);
        checkOutput("jalr_mis.instret", instret, 32'd1);
`endif

        // Randomized cycles against the behavioural model
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        mMode = 0;
        mPc = RV;
        mInstret = 32'd0;
        for (int n = 0; n < 600; n++) begin
            logic a, b, done, st, rdy;
            logic [31:0] immV, rs1V;
            if ($urandom_range(0, 63) == 0 || (mMode == 3 && $urandom_range(0, 7) == 0)) begin
                reset_n = 1'b0;
                #1;
                mMode = 0;
                mPc = RV;
                mInstret = 32'd0;
                checkResetValues("rand_rst");
                tick();
                reset_n = 1'b1;
                continue;
            end
            a    = 1'($urandom_range(0, 1));
            b    = 1'($urandom_range(0, 1));
            done = 1'($urandom_range(0, 1));
            st   = ($urandom_range(0, 3) == 0);
            rdy  = 1'($urandom_range(0, 1));
            immV = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rs1V = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            applyStimulus(a, b, immV, rs1V, done, st, rdy);

            case (mMode)
                0: mMode = 1;
                1: if (rdy) mMode = 2;
                2: begin
                    if (done && !st) begin
                        tgt = (b ? rs1V : mPc) + (a ? immV : 32'd4);
                        if (a && b) tgt[0] = 1'b0;
`ifdef PCGEN_MISALIGN_TRAP_EN
                        if (tgt[1:0] != 2'b00) mMode = 3;
                        else begin
`else
                        begin
`endif
                            mPc = tgt;
                            mInstret = mInstret + 32'd1;
                            mMode = 1;
                        end
                    end
                end
                default: ;
            endcase

            tick();
            checkOutput("rand.pc", pc, mPc);
            checkOutput("rand.if_addr", if_addr, mPc);
            checkOutput("rand.instret", instret, mInstret);
            checkOutput("rand.if_valid", 32'(if_valid), 32'(mMode == 1));
`ifdef PCGEN_MISALIGN_TRAP_EN
            checkOutput("rand.trap", 32'(trap), 32'(mMode == 3));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator for the single-issue RV32I core. It consumes the branch-condition selects `pcAsrc`/`pcBsrc` and computes the next PC, registers it, and issues instruction-fetch requests to instruction memory over a valid/ready handshake. It sits between the execute stage (branch resolution) and the instruction-memory port, and closes the loop from branch decision back to fetch. It also counts retired instructions and, when configured, traps on misaligned targets.

## Interface
- `RESET_VECTOR`, default 32'h0000_0000, PC loaded on reset.
- `clock` in 1, single clock; all state updates on the rising edge.
- `reset_n` in 1, asynchronous, active-low reset.
- `pcAsrc` in 1, addend select: 0 → +4, 1 → +imm.
- `pcBsrc` in 1, base select: 0 → PC, 1 → rs1.
- `imm` in 32, sign-extended branch/jump immediate.
- `rs1` in 32, register operand for JALR.
- `exec_done` in 1, execute stage has resolved the current instruction; selects and operands are valid this cycle.
- `stall` in 1, holds the PC update while high.
- `if_valid` out 1, fetch request valid.
- `if_ready` in 1, instruction memory accepts the request.
- `if_addr` out 32, fetch address.
- `pc` out 32, PC of the instruction in flight.
- `pc_plus4` out 32, `pc + 4`, used as the link value.
- `instret` out 32, retired-instruction count.
- `trap` out 1, misaligned-target trap. Present only with the macro defined.

## Operation
- States:
  - BOOT: one cycle after reset release; `if_valid`=0.
  - FETCH: `if_valid`=1 and `if_addr`=`pc`.
  - EXEC: waits for resolution.
  - TRAP: sticky.
- BOOT always goes to FETCH.
- FETCH goes to EXEC on `if_valid & if_ready`.
- Once `if_valid` is asserted, `if_valid` and `if_addr` stay stable until accepted. `stall` does not affect FETCH.
- EXEC updates the PC on `exec_done & !stall`:
  - `next = (pcBsrc ? rs1 : pc) + (pcAsrc ? imm : 32'd4)`, computed modulo 2^32.
  - When `pcAsrc & pcBsrc` (JALR), `next[0]` is forced to 0.
  - Registers `pc <= next` and `instret <= instret + 1` (wraps at 2^32), then returns to FETCH.
- EXEC with `exec_done & stall`: no update; stays in EXEC. Execute keeps `exec_done` asserted until the stall clears.
- EXEC with `!exec_done`: stays in EXEC.
- Any select combination is accepted. `{pcAsrc,pcBsrc}=01` yields `rs1 + 4` with no special handling.
- `pc_plus4` is combinational from `pc`: 32'hFFFF_FFFC gives 32'h0000_0000.

## Timing
- Reset values: `pc`=`RESET_VECTOR`, `instret`=0, state=BOOT, `if_valid`=0, `trap`=0. `if_addr` follows `pc`.
- Reset asserted mid-operation (any state, including an unaccepted fetch) returns to these values immediately. The pending request is dropped.
- Reset release followed by `if_valid`=1 takes one cycle (BOOT).
- A fetch accepted in cycle N puts the block in EXEC in cycle N+1. `exec_done` is honoured from N+1 onward.
- The resolve at edge M makes the new `pc` visible after M, with `if_valid`=1 in the same cycle (1-cycle redirect latency).
- Minimum loop is 2 cycles per instruction: FETCH accepted, then EXEC resolved.
- `exec_done` outside EXEC is ignored. `instret` does not change.

## Configuration
- `PCGEN_MISALIGN_TRAP_EN`:
  - Defined: the `trap` port exists. An EXEC resolve with `next[1:0] != 2'b00` (after JALR LSB clear) does not update `pc` and does not increment `instret`. The block enters TRAP, where `trap`=1 and `if_valid`=0 until reset.
  - Undefined: no `trap` port and no TRAP state. `next` is loaded unchanged and fetch proceeds at the misaligned address.

## Test plan
- Reset, `RESET_VECTOR`=32'h0000_1000: `if_valid`=0 for one cycle after release, then `if_valid`=1 with `if_addr`=32'h1000 held for 3 cycles of `if_ready`=0; `instret`=0.
- Sequential path: fetch 0x1000, then `exec_done`, `{pcAsrc,pcBsrc}=00` → `pc`=0x1004, `instret`=1, next `if_addr`=0x1004.
- Branch taken: `pc`=0x1004, `pcAsrc`=1, `imm`=32'hFFFF_FFF8 → `pc`=0x0FFC. JALR: `rs1`=0x2003, `imm`=0 → `pc`=0x2002 (macro off) or TRAP with `trap`=1 and `pc` unchanged (macro on).
- Stall: `exec_done`=1 with `stall`=1 for 2 cycles → `pc` and `instret` unchanged. `stall`=0 → updates exactly once.
- Wrap: `pc`=32'hFFFF_FFFC sequential → `pc`=0, `pc_plus4` 0→4. `instret` preloaded via 2^32−1 resolves wraps to 0.
- Reset asserted in EXEC and in TRAP → outputs immediately at reset values; the fetch restarts from `RESET_VECTOR`.
